// File: rtl/uart_pkg.sv
// Shared encodings and oversampling constants for the UART receive/transmit slice.
// UART_RX_PARITY_EN widens the state encoding to make room for the parity state.
package uart_pkg;

    localparam int unsigned OS_RATE  = 16;
    localparam int unsigned MID_TICK = 7;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] START  = 2'b01;
    localparam logic [1:0] DATA   = 2'b10;
    localparam logic [1:0] STOP   = 2'b11;
    localparam logic [2:0] PARITY = 3'b100;

`ifdef UART_RX_PARITY_EN
    localparam int unsigned STATE_W = 3;
`else
    localparam int unsigned STATE_W = 2;
`endif

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = STATE_W'(IDLE),
        ST_START = STATE_W'(START),
        ST_DATA  = STATE_W'(DATA),
        ST_STOP  = STATE_W'(STOP)
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = STATE_W'(PARITY)
`endif
    } state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL selects the flop reset value so idle-high lines do not glitch out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start detect, mid-bit sampling, LSB-first deserializer.
// Optional parity check and parity_err port are enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter logic        PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    state_e      state_q;
    logic [4:0]  s_q;
    logic [2:0]  n_q;
    logic [7:0]  b_q;
    logic        done_q;
    logic        ferr_q;
    logic        rx_s;
    logic [7:0]  dout_w;
`ifdef UART_RX_PARITY_EN
    logic        par_q;
    logic        perr_q;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Bits enter at the MSB, so a short frame ends up left-justified in b_q.
    assign dout_w = b_q >> (8 - DBIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s_q == 5'(MID_TICK)) begin
                            s_q <= '0;
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                n_q     <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_q == 5'(OS_RATE - 1)) begin
                            s_q <= '0;
                            b_q <= {rx_s, b_q[7:1]};
                            if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end else begin
                                n_q <= n_q + 3'd1;
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_q == 5'(OS_RATE - 1)) begin
                            s_q     <= '0;
                            par_q   <= rx_s;
                            state_q <= ST_STOP;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (s_tick) begin
                        if (s_q == 5'(SB_TICK - 1)) begin
                            done_q  <= 1'b1;
                            ferr_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= ((^dout_w) ^ par_q) != PARITY_ODD;
`endif
                            state_q <= ST_IDLE;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign dout         = dout_w;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule
